// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch / data memory port arbiter.
package mem_arb_pkg;

    // Arbiter sequencing state: idle, or waiting on an access owned by IF or D.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IF_WAIT = 2'd1,
        ARB_D_WAIT  = 2'd2
    } arb_state_t;

    // Which requester drives the memory port in a grant cycle.
    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } arb_gnt_t;

    // Counter width able to hold the value max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CW = cnt_width(MAX);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX);

    logic [CW-1:0] cnt;

    // Clear wins over increment; the count parks at MAX until fetch gets a turn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign at_max = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and the data port (D).
// One access in flight at a time; the response returns MEM_LAT cycles after the
// grant, and a fresh grant can only happen on the cycle after the response.
//
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   ARB_IDLE    | no access in flight; a grant (mem_en) may be issued this cycle
//   ARB_IF_WAIT | fetch access in flight; lat_cnt==0 marks the response cycle
//   ARB_D_WAIT  | data access in flight; lat_cnt==0 marks the response cycle
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_pc,
    output logic              stall_mem
);

    localparam int LAT_W = cnt_width(MEM_LAT);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

    arb_state_t        state;
    logic [LAT_W-1:0]  lat_cnt;
    logic              drop;

    logic              is_idle;
    logic              resp_now;
    logic              if_ok;
    logic              starve_at_max;
    logic              gnt_d;
    logic              gnt_if;
    arb_gnt_t          gnt_sel;
    logic              starve_inc;
    logic              starve_clr;

    assign is_idle  = (state == ARB_IDLE);
    assign resp_now = !is_idle && (lat_cnt == '0);
    assign if_ok    = if_req && !if_flush;

    // Grant decision: D normally wins, but yields once fetch has been passed over
    // STARVE_MAX times in a row. Nothing is launched while reset is held.
    always_comb begin
        gnt_d   = 1'b0;
        gnt_if  = 1'b0;
        gnt_sel = GNT_IF;
        if (is_idle && !rst) begin
            if (d_req && !(if_ok && starve_at_max)) begin
                gnt_d   = 1'b1;
                gnt_sel = GNT_D;
            end else if (if_ok) begin
                gnt_if  = 1'b1;
            end
        end
    end

    assign starve_inc = gnt_d && if_req;
    assign starve_clr = gnt_if || (is_idle && !if_req);

    mem_arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk    (clk),
        .rst    (rst),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (starve_at_max)
    );

    // Sequencer: load the latency timer on a grant, count it down, return to idle
    // in the response cycle. A flush while a fetch is in flight marks it dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARB_IDLE;
            lat_cnt <= '0;
            drop    <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    drop <= 1'b0;
                    if (gnt_d) begin
                        state   <= ARB_D_WAIT;
                        lat_cnt <= LAT_LOAD;
                    end else if (gnt_if) begin
                        state   <= ARB_IF_WAIT;
                        lat_cnt <= LAT_LOAD;
                    end
                end
                ARB_IF_WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= ARB_IDLE;
                        drop  <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                        if (if_flush) begin
                            drop <= 1'b1;
                        end
                    end
                end
                ARB_D_WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= ARB_IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    lat_cnt <= '0;
                    drop    <= 1'b0;
                end
            endcase
        end
    end

    // Memory port is driven only in the grant cycle and is zero otherwise.
    always_comb begin
        mem_en    = gnt_d || gnt_if;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_en) begin
            if (gnt_sel == GNT_D) begin
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end else begin
                mem_addr  = if_addr;
            end
        end
    end

    // Response: a flush in the response cycle itself also kills the fetch data.
    always_comb begin
        if_valid = resp_now && (state == ARB_IF_WAIT) && !drop && !if_flush;
        d_valid  = resp_now && (state == ARB_D_WAIT);
        if_rdata = if_valid ? mem_rdata : '0;
        d_rdata  = d_valid  ? mem_rdata : '0;
    end

    // Pipeline stalls: a requester waits until its response pulse; quiet in reset.
    always_comb begin
        stall_pc  = !rst && if_req && !if_valid;
        stall_mem = !rst && d_req  && !d_valid;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter against a cycle-indexed model.
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_flush = 1'b0;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        stall_pc;
    logic        stall_mem;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_pc(stall_pc), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // model: absolute cycle of the pending response, its owner/address, starvation run
    int          resp_cyc = -1;
    bit          m_is_d   = 1'b0;
    logic [31:0] m_addr   = '0;
    bit          m_drop   = 1'b0;
    int          starve   = 0;
    bit          last_ifv = 1'b0;
    bit          last_dv  = 1'b0;

    // memory responder: address pipe of what the DUT issued, oldest first
    bit          pipe_en[$];
    logic [31:0] pipe_addr[$];
    bit          force_rd_en = 1'b0;
    logic [31:0] force_rd    = '0;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h10) return 32'hE3A01005;
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive memory data, compare all outputs to the model, advance.
    task automatic step();
        bit          idle, resp, if_ok, g_d, g_if;
        bit          e_en, e_we, e_ifv, e_dv, e_spc, e_smem;
        logic [31:0] e_addr, e_wdata, e_ifrd, e_drd;

        if (force_rd_en)   mem_rdata = force_rd;
        else if (pipe_en[0]) mem_rdata = rom(pipe_addr[0]);
        else               mem_rdata = $urandom;
        #1;

        e_en = 0; e_we = 0; e_ifv = 0; e_dv = 0; e_spc = 0; e_smem = 0;
        e_addr = '0; e_wdata = '0; e_ifrd = '0; e_drd = '0;
        g_d = 0; g_if = 0;
        if (rst) begin
            resp_cyc = -1;
            m_drop   = 0;
            starve   = 0;
        end else begin
            idle  = (cyc > resp_cyc);
            resp  = (cyc == resp_cyc);
            if_ok = if_req && !if_flush;
            g_d   = idle && d_req && !(if_ok && starve == STARVE_MAX);
            g_if  = idle && !g_d && if_ok;
            e_en    = g_d || g_if;
            e_addr  = g_d ? d_addr : (g_if ? if_addr : 32'h0);
            e_we    = g_d && d_we;
            e_wdata = g_d ? d_wdata : 32'h0;
            e_ifv   = resp && !m_is_d && !m_drop && !if_flush;
            e_dv    = resp && m_is_d;
            e_ifrd  = e_ifv ? rom(m_addr) : 32'h0;
            e_drd   = e_dv  ? rom(m_addr) : 32'h0;
            e_spc   = if_req && !e_ifv;
            e_smem  = d_req && !e_dv;

            if (e_en) begin
                resp_cyc = cyc + MEM_LAT;
                m_is_d   = g_d;
                m_addr   = e_addr;
                m_drop   = 0;
            end else if (!idle && !resp && !m_is_d && if_flush) begin
                m_drop = 1;
            end
            if (g_if)                 starve = 0;
            else if (g_d && if_req)   starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
            else if (idle && !if_req) starve = 0;
        end

        check("mem_en",    32'(mem_en),    32'(e_en));
        check("mem_we",    32'(mem_we),    32'(e_we));
        check("mem_addr",  mem_addr,       e_addr);
        check("mem_wdata", mem_wdata,      e_wdata);
        check("if_valid",  32'(if_valid),  32'(e_ifv));
        check("if_rdata",  if_rdata,       e_ifrd);
        check("d_valid",   32'(d_valid),   32'(e_dv));
        check("d_rdata",   d_rdata,        e_drd);
        check("stall_pc",  32'(stall_pc),  32'(e_spc));
        check("stall_mem", 32'(stall_mem), 32'(e_smem));

        last_ifv = e_ifv;
        last_dv  = e_dv;
        void'(pipe_en.pop_front());
        void'(pipe_addr.pop_front());
        pipe_en.push_back(mem_en);
        pipe_addr.push_back(mem_addr);
        cyc++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if_req = 0; d_req = 0; if_flush = 0; d_we = 0;
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_LAT; i++) begin
            pipe_en.push_back(1'b0);
            pipe_addr.push_back(32'h0);
        end

        // reset with requests asserted: everything must stay quiet
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if_req = 1; if_addr = 32'h10; d_req = 1; d_addr = 32'h40;
            step();
            check("rst_mem_en", 32'(mem_en), 32'h0);
            check("rst_stall_mem", 32'(stall_mem), 32'h0);
        end
        @(negedge clk);
        rst = 0; if_req = 0; d_req = 0;
        step();
        idle_cycles(2);

        // single fetch
        @(negedge clk); if_req = 1; if_addr = 32'h10; step();
        check("fetch_c0_en", 32'(mem_en), 32'h1);
        check("fetch_c0_addr", mem_addr, 32'h10);
        check("fetch_c0_stall", 32'(stall_pc), 32'h1);
        @(negedge clk); step();
        check("fetch_c1_stall", 32'(stall_pc), 32'h1);
        @(negedge clk); step();
        check("fetch_c2_valid", 32'(if_valid), 32'h1);
        check("fetch_c2_rdata", if_rdata, 32'hE3A01005);
        check("fetch_c2_stall", 32'(stall_pc), 32'h0);
        idle_cycles(2);

        // store
        @(negedge clk); d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h55; step();
        check("store_c0_we", 32'(mem_we), 32'h1);
        check("store_c0_wdata", mem_wdata, 32'h55);
        @(negedge clk); step();
        check("store_c1_we", 32'(mem_we), 32'h0);
        @(negedge clk); step();
        check("store_c2_we", 32'(mem_we), 32'h0);
        check("store_c2_valid", 32'(d_valid), 32'h1);
        idle_cycles(2);

        // starvation guard: D,D,IF repeating, one grant every 3 cycles
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if_req = 1; if_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h80;
            step();
            check("starve_en", 32'(mem_en), (k % 3 == 0) ? 32'h1 : 32'h0);
            if (k % 3 == 0)
                check("starve_addr", mem_addr, ((k / 3) % 3 == 2) ? 32'h20 : 32'h80);
        end
        idle_cycles(3);

        // flush while a fetch is in flight
        @(negedge clk); if_req = 1; if_addr = 32'h14; step();
        check("flush_c0_en", 32'(mem_en), 32'h1);
        @(negedge clk); if_flush = 1; if_addr = 32'h30; step();
        @(negedge clk); if_flush = 0; step();
        check("flush_c2_valid", 32'(if_valid), 32'h0);
        check("flush_c2_en", 32'(mem_en), 32'h0);
        @(negedge clk); step();
        check("flush_c3_en", 32'(mem_en), 32'h1);
        check("flush_c3_addr", mem_addr, 32'h30);
        @(negedge clk); step();
        @(negedge clk); step();
        check("flush_c5_valid", 32'(if_valid), 32'h1);
        idle_cycles(2);

        // flush in idle blocks fetch but not data
        @(negedge clk); if_req = 1; if_flush = 1; if_addr = 32'h18; step();
        check("idleflush_en", 32'(mem_en), 32'h0);
        @(negedge clk); d_req = 1; d_we = 0; d_addr = 32'h60; step();
        check("idleflush_d_en", 32'(mem_en), 32'h1);
        check("idleflush_d_addr", mem_addr, 32'h60);
        idle_cycles(4);

        // reset in the middle of a data access
        @(negedge clk); d_req = 1; d_we = 0; d_addr = 32'h44; step();
        check("rstmid_c0_en", 32'(mem_en), 32'h1);
        @(negedge clk); rst = 1; step();
        @(negedge clk); force_rd_en = 1; force_rd = 32'hDEADBEEF; step();
        check("rstmid_c2_dvalid", 32'(d_valid), 32'h0);
        check("rstmid_c2_ifvalid", 32'(if_valid), 32'h0);
        check("rstmid_c2_drdata", d_rdata, 32'h0);
        @(negedge clk); rst = 0; force_rd_en = 0; d_req = 0; step();
        check("rstmid_c3_en", 32'(mem_en), 32'h0);
        @(negedge clk); if_req = 1; if_addr = 32'h10; step();
        check("rstmid_c4_en", 32'(mem_en), 32'h1);
        @(negedge clk); step();
        @(negedge clk); step();
        check("rstmid_c6_valid", 32'(if_valid), 32'h1);
        idle_cycles(2);

        // randomized traffic obeying the hold-until-valid contract
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!if_req || last_ifv || if_flush || $urandom_range(0, 49) == 0) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = $urandom & 32'h3FC;
            end
            if_flush = ($urandom_range(0, 9) == 0);
            if (!d_req || last_dv || $urandom_range(0, 49) == 0) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1) != 0;
                d_addr  = $urandom & 32'h3FC;
                d_wdata = $urandom;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
